// File: rtl/trng_pkg.sv
// Shared types and default tuning constants for the TRNG consumer-side health checker.
package trng_pkg;

  typedef enum logic [1:0] {
    HC_WARMUP,
    HC_RUN,
    HC_ALARM
  } hc_state_t;

  localparam int unsigned SAMPLE_W           = 8;
  localparam int unsigned RCT_CUTOFF_DEF     = 4;
  localparam int unsigned APT_WINDOW_DEF     = 64;
  localparam int unsigned APT_CUTOFF_DEF     = 8;
  localparam int unsigned WARMUP_SAMPLES_DEF = 16;
  localparam int unsigned FIFO_DEPTH_DEF     = 4;

endpackage

// File: rtl/trng_hc_fifo.sv
// Small synchronous FIFO for healthy TRNG bytes; flush empties it in one cycle.
// A push while full is accepted only when a pop happens in the same cycle.
module trng_hc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_FULL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads as zero when nothing is stored.
  assign rdata   = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!n_reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/trng_health_check.sv
// Online RCT/APT health tests on the TRNG byte stream; healthy bytes leave via a FIFO.
// Optional statistics counters (drop_count, fail_count) are built when TRNG_HC_STATS_EN is defined.
module trng_health_check
  import trng_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF     = RCT_CUTOFF_DEF,
  parameter int unsigned APT_WINDOW     = APT_WINDOW_DEF,
  parameter int unsigned APT_CUTOFF     = APT_CUTOFF_DEF,
  parameter int unsigned WARMUP_SAMPLES = WARMUP_SAMPLES_DEF,
  parameter int unsigned FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic [SAMPLE_W-1:0] rand_in,
  input  logic                sample_en,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                clear_alarm,
  output logic                healthy,
  output logic                alarm,
  output logic                rct_fail,
`ifdef TRNG_HC_STATS_EN
  output logic [15:0]         drop_count,
  output logic [7:0]          fail_count,
`endif
  output logic                apt_fail
);

  localparam int unsigned RCT_W   = $clog2(RCT_CUTOFF + 1);
  localparam int unsigned POS_W   = $clog2(APT_WINDOW);
  localparam int unsigned MATCH_W = $clog2(APT_CUTOFF + 1);
  localparam int unsigned WARM_W  = $clog2(WARMUP_SAMPLES + 1);

  localparam logic [RCT_W-1:0]   RCT_MAX   = RCT_W'(RCT_CUTOFF);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(APT_CUTOFF);
  localparam logic [WARM_W-1:0]  WARM_LAST = WARM_W'(WARMUP_SAMPLES - 1);

  hc_state_t           state_q;
  logic [SAMPLE_W-1:0] last_q, ref_q;
  logic [RCT_W-1:0]    rct_cnt_q, rct_cnt_d;
  logic [POS_W-1:0]    apt_pos_q;
  logic [MATCH_W-1:0]  apt_match_q, apt_match_d;
  logic [WARM_W-1:0]   warm_cnt_q;
  logic                healthy_q, alarm_q, rct_fail_q, apt_fail_q;

  logic accept, apt_inc, rct_hit, apt_hit, fail;
  logic fifo_push, fifo_flush, fifo_full, fifo_empty;

  assign accept = sample_en && (state_q != HC_ALARM);

  always_comb begin
    rct_cnt_d   = RCT_W'(1);
    apt_match_d = apt_match_q;
    apt_inc     = 1'b0;
    // A zero run count means no sample has been seen since reset/clear.
    if ((rct_cnt_q != '0) && (rand_in == last_q)) begin
      rct_cnt_d = (rct_cnt_q == RCT_MAX) ? rct_cnt_q : rct_cnt_q + 1'b1;
    end
    if (apt_pos_q == '0) begin
      apt_match_d = MATCH_W'(1);
      apt_inc     = 1'b1;
    end else if (rand_in == ref_q) begin
      apt_inc = 1'b1;
      if (apt_match_q != MATCH_MAX) begin
        apt_match_d = apt_match_q + 1'b1;
      end
    end
    rct_hit = accept && (rct_cnt_d == RCT_MAX);
    apt_hit = accept && apt_inc && (apt_match_d == MATCH_MAX);
    fail    = rct_hit || apt_hit;
  end

  // The failing cycle flushes; a pop in that same cycle has already been taken downstream.
  assign fifo_push  = accept && !fail && (state_q == HC_RUN);
  assign fifo_flush = accept && fail;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q     <= HC_WARMUP;
      last_q      <= '0;
      ref_q       <= '0;
      rct_cnt_q   <= '0;
      apt_pos_q   <= '0;
      apt_match_q <= '0;
      warm_cnt_q  <= '0;
      healthy_q   <= 1'b0;
      alarm_q     <= 1'b0;
      rct_fail_q  <= 1'b0;
      apt_fail_q  <= 1'b0;
    end else begin
      unique case (state_q)
        HC_WARMUP, HC_RUN: begin
          if (accept) begin
            last_q      <= rand_in;
            rct_cnt_q   <= rct_cnt_d;
            apt_pos_q   <= apt_pos_q + 1'b1;
            apt_match_q <= apt_match_d;
            if (apt_pos_q == '0) begin
              ref_q <= rand_in;
            end
            if (fail) begin
              state_q    <= HC_ALARM;
              healthy_q  <= 1'b0;
              alarm_q    <= 1'b1;
              rct_fail_q <= rct_hit;
              apt_fail_q <= apt_hit;
            end else if (state_q == HC_WARMUP) begin
              warm_cnt_q <= warm_cnt_q + 1'b1;
              if (warm_cnt_q == WARM_LAST) begin
                state_q   <= HC_RUN;
                healthy_q <= 1'b1;
              end
            end
          end
        end
        HC_ALARM: begin
          if (clear_alarm) begin
            state_q     <= HC_WARMUP;
            alarm_q     <= 1'b0;
            rct_fail_q  <= 1'b0;
            apt_fail_q  <= 1'b0;
            rct_cnt_q   <= '0;
            apt_pos_q   <= '0;
            apt_match_q <= '0;
            warm_cnt_q  <= '0;
          end
        end
        default: begin
          state_q   <= HC_WARMUP;
          healthy_q <= 1'b0;
          alarm_q   <= 1'b0;
        end
      endcase
    end
  end

  trng_hc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .flush   (fifo_flush),
    .push    (fifo_push),
    .pop     (out_ready),
    .wdata   (rand_in),
    .rdata   (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign healthy   = healthy_q;
  assign alarm     = alarm_q;
  assign rct_fail  = rct_fail_q;
  assign apt_fail  = apt_fail_q;

`ifdef TRNG_HC_STATS_EN
  logic [15:0] drop_q;
  logic [7:0]  fail_cnt_q;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      drop_q     <= '0;
      fail_cnt_q <= '0;
    end else begin
      if (fifo_push && fifo_full && !out_ready && (drop_q != 16'hffff)) begin
        drop_q <= drop_q + 1'b1;
      end
      if (fifo_flush && (fail_cnt_q != 8'hff)) begin
        fail_cnt_q <= fail_cnt_q + 1'b1;
      end
    end
  end

  assign drop_count = drop_q;
  assign fail_count = fail_cnt_q;
`endif

endmodule

// File: tb/tb_trng_health_check.sv
// Directed bench for trng_health_check: a vector table for warm-up/RCT/clear plus
// hand-written sequences for APT windows, FIFO overflow and mid-run reset.
module tb_trng_health_check;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic [7:0] rand_in = 8'h00;
  logic       sample_en = 1'b0;
  logic       out_ready = 1'b0;
  logic       clear_alarm = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, healthy, alarm, rct_fail, apt_fail;
`ifdef TRNG_HC_STATS_EN
  logic [15:0] drop_count;
  logic [7:0]  fail_count;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  trng_health_check dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .rand_in     (rand_in),
    .sample_en   (sample_en),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .clear_alarm (clear_alarm),
    .healthy     (healthy),
    .alarm       (alarm),
    .rct_fail    (rct_fail),
`ifdef TRNG_HC_STATS_EN
    .drop_count  (drop_count),
    .fail_count  (fail_count),
`endif
    .apt_fail    (apt_fail)
  );

  typedef struct {
    logic       en;
    logic [7:0] d;
    logic       rdy;
    logic       clr;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_healthy;
    logic       e_alarm;
    logic       e_rct;
    logic       e_apt;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic en, input logic [7:0] d, input logic rdy,
                              input logic clr, input logic ev, input logic [7:0] ed,
                              input logic eh, input logic ea, input logic er, input logic ep);
    vec_t v;
    v.en = en; v.d = d; v.rdy = rdy; v.clr = clr;
    v.e_valid = ev; v.e_data = ed; v.e_healthy = eh; v.e_alarm = ea; v.e_rct = er; v.e_apt = ep;
    return v;
  endfunction

  function automatic logic [7:0] filler(input int p);
    return 8'h80 + 8'(p % 64);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs at a falling edge; on return the following rising edge has been applied.
  task automatic cyc(input logic en, input logic [7:0] d, input logic rdy, input logic clr);
    sample_en = en; rand_in = d; out_ready = rdy; clear_alarm = clr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    n_reset = 1'b0; sample_en = 1'b0; clear_alarm = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic warmup(input logic [7:0] base);
    for (int i = 0; i < 16; i++) cyc(1'b1, base + 8'(i), 1'b1, 1'b0);
  endtask

  task automatic chk_flags(input string tag, input logic eh, input logic ea, input logic er,
                           input logic ep);
    chk({tag, ".healthy"}, 16'(healthy), 16'(eh));
    chk({tag, ".alarm"}, 16'(alarm), 16'(ea));
    chk({tag, ".rct_fail"}, 16'(rct_fail), 16'(er));
    chk({tag, ".apt_fail"}, 16'(apt_fail), 16'(ep));
  endtask

  // 64-sample window with 0x3C as reference and n occurrences at even positions.
  task automatic apt_window(input int n);
    for (int p = 0; p < 64; p++) begin
      if ((p % 2 == 0) && (p / 2 < n)) cyc(1'b1, 8'h3C, 1'b1, 1'b0);
      else cyc(1'b1, filler(p), 1'b1, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] drain_exp[4];

    // Warm-up, first delivery, RCT failure, alarm holds, clear back to WARMUP.
    for (int i = 0; i < 16; i++)
      vecs[i] = mk(1, 8'(i + 1), 1, 0, 0, 8'h00, (i == 15), 0, 0, 0);
    vecs[16] = mk(1, 8'h11, 1, 0, 1, 8'h11, 1, 0, 0, 0);
    vecs[17] = mk(1, 8'hA5, 1, 0, 1, 8'hA5, 1, 0, 0, 0);
    vecs[18] = mk(1, 8'hA5, 1, 0, 1, 8'hA5, 1, 0, 0, 0);
    vecs[19] = mk(1, 8'hA5, 1, 0, 1, 8'hA5, 1, 0, 0, 0);
    vecs[20] = mk(1, 8'hA5, 1, 0, 0, 8'h00, 0, 1, 1, 0);
    vecs[21] = mk(1, 8'h5A, 1, 0, 0, 8'h00, 0, 1, 1, 0);
    vecs[22] = mk(0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    vecs[23] = mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0);

    do_reset();
    chk("reset.valid", 16'(out_valid), 16'h0);
    chk("reset.data", 16'(out_data), 16'h0);
    chk_flags("reset", 0, 0, 0, 0);
`ifdef TRNG_HC_STATS_EN
    chk("reset.drop_count", drop_count, 16'h0);
    chk("reset.fail_count", 16'(fail_count), 16'h0);
`endif

    for (int i = 0; i < NV; i++) begin
      cyc(vecs[i].en, vecs[i].d, vecs[i].rdy, vecs[i].clr);
      chk($sformatf("v%0d.valid", i), 16'(out_valid), 16'(vecs[i].e_valid));
      if (vecs[i].e_valid) chk($sformatf("v%0d.data", i), 16'(out_data), 16'(vecs[i].e_data));
      chk_flags($sformatf("v%0d", i), vecs[i].e_healthy, vecs[i].e_alarm, vecs[i].e_rct,
                vecs[i].e_apt);
    end
`ifdef TRNG_HC_STATS_EN
    chk("table.fail_count", 16'(fail_count), 16'h1);
`endif

    // After clear: 16 fresh samples are discarded, then output resumes.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0);
      chk($sformatf("rewarm%0d.valid", i), 16'(out_valid), 16'h0);
    end
    chk("rewarm.healthy", 16'(healthy), 16'h1);
    cyc(1'b1, 8'h60, 1'b1, 1'b0);
    chk("rewarm.first_valid", 16'(out_valid), 16'h1);
    chk("rewarm.first_data", 16'(out_data), 16'h60);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk_flags("clr_in_run", 1, 0, 0, 0);
    chk("clr_in_run.valid", 16'(out_valid), 16'h0);
`ifdef TRNG_HC_STATS_EN
    chk("clr_in_run.fail_count", 16'(fail_count), 16'h1);
`endif

    // APT: 7+7 occurrences across two windows pass, 8 within one window fail.
    do_reset();
    for (int k = 0; k < 64; k++) cyc(1'b1, filler(k), 1'b1, 1'b0);
    apt_window(7);
    apt_window(7);
    chk_flags("apt_split", 1, 0, 0, 0);
    for (int j = 0; j < 7; j++) begin
      cyc(1'b1, 8'h3C, 1'b1, 1'b0);
      cyc(1'b1, 8'h01 + 8'(j), 1'b1, 1'b0);
    end
    chk_flags("apt_seven", 1, 0, 0, 0);
    chk("apt_seven.valid", 16'(out_valid), 16'h1);
    chk("apt_seven.data", 16'(out_data), 16'h07);
    cyc(1'b1, 8'h3C, 1'b1, 1'b0);
    chk_flags("apt_eight", 0, 1, 0, 1);
    chk("apt_eight.valid", 16'(out_valid), 16'h0);

    // FIFO overflow: 4 held, 2 dropped, then full push+pop, then drain in order.
    do_reset();
    warmup(8'h10);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 8'h21 + 8'(i), 1'b0, 1'b0);
      if (i == 3) chk("full.valid", 16'(out_valid), 16'h1);
    end
    chk("over.data", 16'(out_data), 16'h21);
`ifdef TRNG_HC_STATS_EN
    chk("over.drop_count", drop_count, 16'h2);
`endif
    cyc(1'b1, 8'h27, 1'b1, 1'b0);
    drain_exp[0] = 8'h22; drain_exp[1] = 8'h23; drain_exp[2] = 8'h24; drain_exp[3] = 8'h27;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d.valid", k), 16'(out_valid), 16'h1);
      chk($sformatf("drain%0d.data", k), 16'(out_data), 16'(drain_exp[k]));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain.empty", 16'(out_valid), 16'h0);
`ifdef TRNG_HC_STATS_EN
    chk("drain.drop_count", drop_count, 16'h2);
`endif

    // Reset with bytes queued discards them and returns to WARMUP.
    do_reset();
    warmup(8'h30);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h51 + 8'(i), 1'b0, 1'b0);
    chk("prereset.valid", 16'(out_valid), 16'h1);
    n_reset = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("midreset.valid", 16'(out_valid), 16'h0);
    chk("midreset.data", 16'(out_data), 16'h0);
    chk_flags("midreset", 0, 0, 0, 0);
    n_reset = 1'b1;
    cyc(1'b1, 8'h70, 1'b1, 1'b0);
    chk("postreset.valid", 16'(out_valid), 16'h0);
    chk("postreset.healthy", 16'(healthy), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
